// File: rtl/traffic_light_ctrl_act_if.sv
// traffic_light_ctrl_act_if
//   Bundles the sensor inputs and the lamp/status outputs of the actuated
//   intersection controller.
//   slave  : controller view (sensors in, lamps/status out)
//   master : environment view (drives sensors, observes lamps/status)
//   side_car   sensor level, side-road vehicle present
//   ped_btn    pedestrian push button
//   flash_en   night flashing mode request
//   main_light main-road lamp  (00 red, 01 yellow, 10 green)
//   side_light side-road lamp  (same encoding)
//   walk       pedestrian walk lamp
//   state_o    current controller state code
interface traffic_light_ctrl_act_if;
  logic       side_car;
  logic       ped_btn;
  logic       flash_en;
  logic [1:0] main_light;
  logic [1:0] side_light;
  logic       walk;
  logic [2:0] state_o;

  modport master (
    output side_car, ped_btn, flash_en,
    input  main_light, side_light, walk, state_o
  );

  modport slave (
    input  side_car, ped_btn, flash_en,
    output main_light, side_light, walk, state_o
  );
endinterface

// File: rtl/traffic_light_ctrl_act.sv
// traffic_light_ctrl_act
//   Sensor-actuated two-road intersection controller. Main road rests in
//   green; a latched side-car or pedestrian request runs one side-road
//   cycle with all-red clearance on both changeovers. A night mode flashes
//   the main lamp yellow.
//   clk  : system clock
//   rst  : asynchronous, active-high reset (returns to ALL_RED_2)
//   bus  : slave modport -- side_car, ped_btn, flash_en in;
//          main_light, side_light, walk, state_o out
//   All durations are in clk cycles and must lie in 1 .. 2^TIMER_W-1.
module traffic_light_ctrl_act #(
  parameter int TIMER_W        = 8,
  parameter int MAIN_GREEN_MIN = 8,
  parameter int YELLOW_T       = 3,
  parameter int ALL_RED_T      = 2,
  parameter int SIDE_GREEN_T   = 6,
  parameter int FLASH_HALF     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  traffic_light_ctrl_act_if.slave        bus
);

  typedef enum logic [2:0] {
    S_MAIN_GREEN  = 3'd0,
    S_MAIN_YELLOW = 3'd1,
    S_ALL_RED_1   = 3'd2,
    S_SIDE_GREEN  = 3'd3,
    S_SIDE_YELLOW = 3'd4,
    S_ALL_RED_2   = 3'd5,
    S_FLASH       = 3'd6
  } state_e;

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;

  // Last timer value of each dwell: a state of duration D leaves when timer == D-1.
  localparam logic [TIMER_W-1:0] MG_LAST = TIMER_W'(MAIN_GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] YL_LAST = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] AR_LAST = TIMER_W'(ALL_RED_T - 1);
  localparam logic [TIMER_W-1:0] SG_LAST = TIMER_W'(SIDE_GREEN_T - 1);
  localparam logic [TIMER_W-1:0] FH_LAST = TIMER_W'(FLASH_HALF - 1);

  // Kept as a raw 3-bit register so the unused code 7 is representable
  // and explicitly steered back to ALL_RED_2.
  logic [2:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               car_lat_q, car_lat_d;
  logic               ped_lat_q, ped_lat_d;
  logic               walk_srv_q, walk_srv_d;
  logic               flash_ph_q, flash_ph_d;
  logic               enter_sg, leave_sg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_ALL_RED_2;
      timer_q    <= '0;
      car_lat_q  <= 1'b0;
      ped_lat_q  <= 1'b0;
      walk_srv_q <= 1'b0;
      flash_ph_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      car_lat_q  <= car_lat_d;
      ped_lat_q  <= ped_lat_d;
      walk_srv_q <= walk_srv_d;
      flash_ph_q <= flash_ph_d;
    end
  end

  // Next state, timer, flash phase and request latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MAIN_GREEN:  if (timer_q == MG_LAST && (car_lat_q || ped_lat_q)) state_d = S_MAIN_YELLOW;
      S_MAIN_YELLOW: if (timer_q == YL_LAST) state_d = S_ALL_RED_1;
      S_ALL_RED_1:   if (timer_q == AR_LAST) state_d = S_SIDE_GREEN;
      S_SIDE_GREEN:  if (timer_q == SG_LAST) state_d = S_SIDE_YELLOW;
      S_SIDE_YELLOW: if (timer_q == YL_LAST) state_d = S_ALL_RED_2;
      S_ALL_RED_2:   if (timer_q == AR_LAST) state_d = S_MAIN_GREEN;
      S_FLASH:       if (!bus.flash_en) state_d = S_ALL_RED_2;
      default:       state_d = S_ALL_RED_2;
    endcase
    // Night mode pre-empts any legal sequencing state regardless of the timer;
    // the illegal code still recovers through ALL_RED_2 first.
    if (bus.flash_en && state_q != S_FLASH && state_q != 3'd7) state_d = S_FLASH;

    // Timer restarts on every state entry. Main green parks at its minimum
    // so a late request leaves on the very next clk.
    if (state_d != state_q)
      timer_d = '0;
    else if (state_q == S_FLASH)
      timer_d = (timer_q == FH_LAST) ? '0 : timer_q + 1'b1;
    else if (state_q == S_MAIN_GREEN && timer_q == MG_LAST)
      timer_d = timer_q;
    else
      timer_d = timer_q + 1'b1;

    // Phase only advances while staying in FLASH; entering or leaving zeroes it.
    flash_ph_d = 1'b0;
    if (state_q == S_FLASH && state_d == S_FLASH)
      flash_ph_d = (timer_q == FH_LAST) ? ~flash_ph_q : flash_ph_q;

    enter_sg = (state_d == S_SIDE_GREEN) && (state_q != S_SIDE_GREEN);
    leave_sg = (state_q == S_SIDE_GREEN) && (state_d != S_SIDE_GREEN);

    // Requests are consumed on side-green entry; a press on that same clk is
    // not kept in the latch but still earns the walk lamp via walk_srv.
    car_lat_d  = enter_sg ? 1'b0 : (car_lat_q | bus.side_car);
    ped_lat_d  = enter_sg ? 1'b0 : (ped_lat_q | bus.ped_btn);
    walk_srv_d = walk_srv_q;
    if (enter_sg)      walk_srv_d = ped_lat_q | bus.ped_btn;
    else if (leave_sg) walk_srv_d = 1'b0;
  end

  // Lamp decode from registered state only; unknown codes show all red.
  always_comb begin
    bus.main_light = L_RED;
    bus.side_light = L_RED;
    bus.walk       = 1'b0;
    bus.state_o    = state_q;
    case (state_q)
      S_MAIN_GREEN:  bus.main_light = L_GRN;
      S_MAIN_YELLOW: bus.main_light = L_YEL;
      S_SIDE_GREEN: begin
        bus.side_light = L_GRN;
        bus.walk       = walk_srv_q;
      end
      S_SIDE_YELLOW: bus.side_light = L_YEL;
      S_FLASH:       bus.main_light = flash_ph_q ? L_RED : L_YEL;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl_act.sv
// Directed bench for traffic_light_ctrl_act with default parameters.
// Cycle c is the c-th rising edge counted from the edge on which rst is
// released (rst drops 1ns after that edge); values are sampled 1ns after
// each edge and inputs are changed at that point for the next edge.
module tb_traffic_light_ctrl_act;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   viol  = 0;
  bit   chk_on = 1'b0;

  traffic_light_ctrl_act_if tif();

  traffic_light_ctrl_act dut (
    .clk (clk),
    .rst (rst),
    .bus (tif)
  );

  always #5 clk = ~clk;

  // Lamp invariants watched on the falling edge during the random run.
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      if (tif.main_light != 2'b00 && tif.side_light != 2'b00) viol++;
      if (tif.walk && (tif.state_o != 3'd3 || tif.side_light != 2'b10)) viol++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns after cycle 0.
  task automatic reset_dut();
    rst = 1'b1;
    tif.side_car = 1'b0;
    tif.ped_btn  = 1'b0;
    tif.flash_en = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Expected lamps {main, side, walk} for a state code.
  function automatic logic [4:0] lamps(input logic [2:0] st, input logic wk, input logic ph);
    case (st)
      3'd0:    return {2'b10, 2'b00, 1'b0};
      3'd1:    return {2'b01, 2'b00, 1'b0};
      3'd3:    return {2'b00, 2'b10, wk};
      3'd4:    return {2'b00, 2'b01, 1'b0};
      3'd6:    return {(ph ? 2'b00 : 2'b01), 2'b00, 1'b0};
      default: return 5'b0;
    endcase
  endfunction

  // State during a side cycle whose MAIN_YELLOW starts at cycle s:
  // MY 3, AR1 2, SG 6, SY 3, AR2 2, then MAIN_GREEN.
  function automatic logic [2:0] side_seq(input int c, input int s);
    int d;
    d = c - s;
    if (d < 0)  return 3'd0;
    if (d < 3)  return 3'd1;
    if (d < 5)  return 3'd2;
    if (d < 11) return 3'd3;
    if (d < 14) return 3'd4;
    if (d < 16) return 3'd5;
    return 3'd0;
  endfunction

  task automatic test_reset();
    logic [7:0] got;
    rst = 1'b1;
    tif.side_car = 1'b1;
    tif.ped_btn  = 1'b1;
    tif.flash_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {tif.state_o, tif.main_light, tif.side_light, tif.walk};
      total++;
      if (got !== {3'd5, 5'b0}) begin
        bad++;
        $display("FAIL reset i=%0d got st/m/s/w=%b want %b", i, got, {3'd5, 5'b0});
      end
    end
  endtask

  task automatic test_power_up();
    logic [2:0] es;
    reset_dut();
    for (int c = 0; c <= 100; c++) begin
      if (c > 0) tick();
      es = (c < 2) ? 3'd5 : 3'd0;
      total++;
      if ({tif.state_o, tif.main_light, tif.side_light, tif.walk} !== {es, lamps(es, 1'b0, 1'b0)}) begin
        bad++;
        $display("FAIL power_up c=%0d got st=%0d m=%b s=%b w=%b want st=%0d lamps=%b",
                 c, tif.state_o, tif.main_light, tif.side_light, tif.walk, es, lamps(es, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_side_car();
    logic [2:0] es;
    reset_dut();
    for (int c = 0; c <= 27; c++) begin
      if (c > 0) tick();
      es = (c < 2) ? 3'd5 : side_seq(c, 10);
      total++;
      if ({tif.state_o, tif.main_light, tif.side_light, tif.walk} !== {es, lamps(es, 1'b0, 1'b0)}) begin
        bad++;
        $display("FAIL side_car c=%0d got st=%0d m=%b s=%b w=%b want st=%0d lamps=%b",
                 c, tif.state_o, tif.main_light, tif.side_light, tif.walk, es, lamps(es, 1'b0, 1'b0));
      end
      tif.side_car = (c == 4);
    end
  endtask

  // Continues from test_side_car at cycle 27.
  task automatic test_ped_pulse();
    logic [2:0] es;
    for (int c = 28; c <= 52; c++) begin
      tick();
      es = side_seq(c, 34);
      total++;
      if ({tif.state_o, tif.main_light, tif.side_light, tif.walk} !== {es, lamps(es, 1'b1, 1'b0)}) begin
        bad++;
        $display("FAIL ped_pulse c=%0d got st=%0d m=%b s=%b w=%b want st=%0d lamps=%b",
                 c, tif.state_o, tif.main_light, tif.side_light, tif.walk, es, lamps(es, 1'b1, 1'b0));
      end
      tif.ped_btn = (c == 29);
    end
  endtask

  // sc 0: ped_btn high on SIDE_GREEN entry clk and the next -> walk, extra cycle.
  // sc 1: ped_btn high only on the entry clk -> walk, latch cleared, no extra cycle.
  task automatic test_ped_entry();
    logic [2:0] es;
    logic       ew;
    for (int sc = 0; sc < 2; sc++) begin
      reset_dut();
      for (int c = 0; c <= 60; c++) begin
        if (c > 0) tick();
        if (c < 2)                      es = 3'd5;
        else if (c < 26)                es = side_seq(c, 10);
        else if (sc == 0 && c < 50)     es = side_seq(c, 34);
        else                            es = 3'd0;
        ew = 1'b1;
        total++;
        if ({tif.state_o, tif.main_light, tif.side_light, tif.walk} !== {es, lamps(es, ew, 1'b0)}) begin
          bad++;
          $display("FAIL ped_entry sc=%0d c=%0d got st=%0d m=%b s=%b w=%b want st=%0d lamps=%b",
                   sc, c, tif.state_o, tif.main_light, tif.side_light, tif.walk, es, lamps(es, ew, 1'b0));
        end
        tif.side_car = (c == 4);
        tif.ped_btn  = (sc == 0) ? (c == 14 || c == 15) : (c == 14);
      end
    end
  endtask

  task automatic test_flash();
    logic [2:0] es;
    logic       ew, ep;
    reset_dut();
    for (int c = 0; c <= 50; c++) begin
      if (c > 0) tick();
      ep = 1'b0;
      if (c < 2)        es = 3'd5;
      else if (c < 17)  es = side_seq(c, 10);
      else if (c < 29) begin
        es = 3'd6;
        ep = (((c - 17) / 4) % 2) == 1;
      end
      else if (c < 31)  es = 3'd5;
      else              es = side_seq(c, 39);
      ew = (c >= 44);
      total++;
      if ({tif.state_o, tif.main_light, tif.side_light, tif.walk} !== {es, lamps(es, ew, ep)}) begin
        bad++;
        $display("FAIL flash c=%0d got st=%0d m=%b s=%b w=%b want st=%0d lamps=%b",
                 c, tif.state_o, tif.main_light, tif.side_light, tif.walk, es, lamps(es, ew, ep));
      end
      tif.side_car = (c == 4);
      tif.flash_en = (c >= 16 && c <= 27);
      tif.ped_btn  = (c == 19);
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] es;
    logic [7:0] got;
    reset_dut();
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) tick();
      es = (c < 2) ? 3'd5 : side_seq(c, 10);
      total++;
      if (tif.state_o !== es) begin
        bad++;
        $display("FAIL async_pre c=%0d got st=%0d want st=%0d", c, tif.state_o, es);
      end
      tif.side_car = (c == 4);
    end
    // Mid MAIN_YELLOW, between clock edges.
    #2 rst = 1'b1;
    #1;
    got = {tif.state_o, tif.main_light, tif.side_light, tif.walk};
    total++;
    if (got !== {3'd5, 5'b0}) begin
      bad++;
      $display("FAIL async_now got st/m/s/w=%b want %b", got, {3'd5, 5'b0});
    end
    tick();
    got = {tif.state_o, tif.main_light, tif.side_light, tif.walk};
    total++;
    if (got !== {3'd5, 5'b0}) begin
      bad++;
      $display("FAIL async_next got st/m/s/w=%b want %b", got, {3'd5, 5'b0});
    end
    // The pending side-car request must be gone: main green holds.
    reset_dut();
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) tick();
      es = (c < 2) ? 3'd5 : 3'd0;
      total++;
      if (tif.state_o !== es) begin
        bad++;
        $display("FAIL async_post c=%0d got st=%0d want st=%0d", c, tif.state_o, es);
      end
    end
  endtask

  task automatic test_illegal();
    logic [4:0] got;
    logic [2:0] es;
    reset_dut();
    for (int c = 1; c <= 4; c++) tick();
    force dut.state_q = 3'd7;
    #1;
    release dut.state_q;
    #1;
    got = {tif.main_light, tif.side_light, tif.walk};
    total++;
    if (got !== 5'b0) begin
      bad++;
      $display("FAIL illegal_lamps got m/s/w=%b want %b", got, 5'b0);
    end
    for (int c = 5; c <= 8; c++) begin
      tick();
      es = (c < 7) ? 3'd5 : 3'd0;
      total++;
      if ({tif.state_o, tif.main_light, tif.side_light, tif.walk} !== {es, lamps(es, 1'b0, 1'b0)}) begin
        bad++;
        $display("FAIL illegal c=%0d got st=%0d m=%b s=%b w=%b want st=%0d",
                 c, tif.state_o, tif.main_light, tif.side_light, tif.walk, es);
      end
    end
  endtask

  task automatic test_random();
    reset_dut();
    viol = 0;
    chk_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      tif.side_car = ($urandom_range(0, 15) == 0);
      tif.ped_btn  = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 199) == 0) tif.flash_en = ~tif.flash_en;
      tick();
    end
    chk_on = 1'b0;
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL random_safety got violations=%0d want 0", viol);
    end
  endtask

  initial begin
    tif.side_car = 1'b0;
    tif.ped_btn  = 1'b0;
    tif.flash_en = 1'b0;
    test_reset();
    test_power_up();
    test_side_car();
    test_ped_pulse();
    test_ped_entry();
    test_flash();
    test_async_reset();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
